// File: rtl/sar_search_if.sv
// Trial/flag/result bundle between the SAR search controller (master) and the
// comparator plus result consumer (slave).
interface sar_search_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] trial;
    logic         cmp_lesser;
    logic         cmp_greater;
    logic         cmp_equal;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         found;
    logic         err;

    modport master (
        input  start, cmp_lesser, cmp_greater, cmp_equal,
        output trial, busy, done, result, found, err
    );

    modport slave (
        output start, cmp_lesser, cmp_greater, cmp_equal,
        input  trial, busy, done, result, found, err
    );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search controller: resolves one bit per cycle, MSB
// first, against an external comparator's lesser/greater/equal flags.
//
// state  | meaning
// IDLE   | waiting for start; trial/result/found/err hold
// SEARCH | trial on comparator, flags sampled each cycle
// DONE   | one-cycle done pulse, outputs valid
module sar_search #(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    sar_search_if.master bus
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t        state, state_n;
    logic [N-1:0]  trial, trial_n;
    logic [N-1:0]  result, result_n;
    logic [KW-1:0] k, k_n;
    logic          found, found_n;
    logic          err, err_n;
    logic [2:0]    flags;
    logic [N-1:0]  bit_k, bit_km1;

    assign flags   = {bus.cmp_lesser, bus.cmp_greater, bus.cmp_equal};
    assign bit_k   = N'(1) << k;
    assign bit_km1 = (k == '0) ? '0 : (N'(1) << (k - KW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            trial  <= '0;
            result <= '0;
            k      <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            trial  <= trial_n;
            result <= result_n;
            k      <= k_n;
            found  <= found_n;
            err    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        trial_n  = trial;
        result_n = result;
        k_n      = k;
        found_n  = found;
        err_n    = err;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    trial_n = N'(1) << (N - 1);
                    k_n     = KW'(N - 1);
                    found_n = 1'b0;
                    err_n   = 1'b0;
                    state_n = SEARCH;
                end
            end
            SEARCH: begin
                if (!$onehot(flags)) begin
                    err_n    = 1'b1;
                    found_n  = 1'b0;
                    result_n = trial;
                    state_n  = DONE;
                end else if (bus.cmp_equal) begin
                    result_n = trial;
                    found_n  = 1'b1;
                    state_n  = DONE;
                end else if (k == '0) begin
                    // last bit: keep it only if the trial was still below target
                    result_n = bus.cmp_lesser ? trial : (trial & ~N'(1));
                    found_n  = 1'b0;
                    state_n  = DONE;
                end else begin
                    trial_n = bus.cmp_lesser ? (trial | bit_km1)
                                             : ((trial & ~bit_k) | bit_km1);
                    k_n     = k - KW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.trial  = trial;
    assign bus.result = result;
    assign bus.found  = found;
    assign bus.err    = err;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: the bench plays the comparator and checks
// every trial and each done against a textbook SAR model.
module tb_sar_search;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sar_search_if #(.N(N)) bus();
    sar_search #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;

    int         tgt = 0;
    int         force_cyc = 0;
    logic [2:0] force_val = 3'b000;

    bit active = 0;
    int cyc = 0;
    int exp_trials[N];
    int exp_len = 0;
    int exp_result = 0;
    bit exp_found = 0;
    bit exp_err = 0;
    int hold_result = 0;
    int hold_trial = 0;
    bit hold_found = 0;
    bit hold_err = 0;
    int last_done_cyc = 0;
    int done_count = 0;
    int trial_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Textbook SAR: try each bit MSB first, keep it while the trial stays at or
    // below the target; stop on equality or on an injected bad-flag cycle.
    task automatic model(input int t, input int fc);
        int acc = 0;
        bit stop = 0;
        exp_len = 0;
        exp_found = 0;
        exp_err = 0;
        exp_result = 0;
        for (int b = N - 1; b >= 0 && !stop; b--) begin
            int tr;
            tr = acc | (1 << b);
            exp_trials[exp_len] = tr;
            exp_len++;
            if (exp_len == fc) begin
                exp_err = 1; exp_result = tr; stop = 1;
            end else if (tr == t) begin
                exp_found = 1; exp_result = tr; stop = 1;
            end else if (tr < t) begin
                acc = tr;
            end
        end
        if (!stop) exp_result = acc;
    endtask

    // Comparator: honest flags unless a fault is injected for one search cycle.
    always_comb begin
        logic [2:0] f;
        f = {(int'(bus.trial) < tgt), (int'(bus.trial) > tgt), (int'(bus.trial) == tgt)};
        if (active && force_cyc != 0 && cyc == force_cyc) f = force_val;
        bus.cmp_lesser  = f[2];
        bus.cmp_greater = f[1];
        bus.cmp_equal   = f[0];
    end

    always @(negedge clk) begin
        if (bus.done === 1'b1) done_count++;
        if (!rst_n) begin
            active = 0;
            chk("rst_trial", bus.trial, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_result", bus.result, 0);
            chk("rst_found", bus.found, 0);
            chk("rst_err", bus.err, 0);
            hold_result = 0; hold_trial = 0; hold_found = 0; hold_err = 0;
        end else if (active) begin
            cyc++;
            if (cyc <= exp_len) begin
                trial_log.push_back(int'(bus.trial));
                chk("trial", bus.trial, exp_trials[cyc-1]);
                chk("busy_search", bus.busy, 1);
                chk("done_early", bus.done, 0);
            end else begin
                chk("done", bus.done, 1);
                chk("busy_done", bus.busy, 1);
                chk("result", bus.result, exp_result);
                chk("found", bus.found, exp_found);
                chk("err", bus.err, exp_err);
                last_done_cyc = cyc;
                hold_result = exp_result;
                hold_found = exp_found;
                hold_err = exp_err;
                hold_trial = exp_trials[exp_len-1];
                active = 0;
            end
        end else begin
            chk("idle_busy", bus.busy, 0);
            chk("idle_done", bus.done, 0);
            chk("idle_result", bus.result, hold_result);
            chk("idle_found", bus.found, hold_found);
            chk("idle_err", bus.err, hold_err);
            chk("idle_trial", bus.trial, hold_trial);
            if (bus.start === 1'b1) begin
                model(tgt, force_cyc);
                trial_log.delete();
                cyc = 0;
                active = 1;
            end
        end
    end

    task automatic do_run(input int t, input int fc, input logic [2:0] fv, input int pulse_at);
        int n;
        tgt = t; force_cyc = fc; force_val = fv;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        if (pulse_at > 0) begin
            repeat (pulse_at - 1) @(posedge clk);
            #1 bus.start = 1'b1;
            @(posedge clk); #1 bus.start = 1'b0;
        end
        n = 0;
        while (active && n < 30) begin
            @(posedge clk);
            n++;
        end
        chk("run_timeout", active, 0);
        @(posedge clk);
    endtask

    int lit100[6] = '{128, 64, 96, 112, 104, 100};
    logic [2:0] bad_flags[5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    initial begin
        int d0, n, dn;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("por_trial", bus.trial, 0);
        chk("por_busy", bus.busy, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_run(100, 0, 3'b000, 0);
        chk("t100_done_cyc", last_done_cyc, 7);
        chk("t100_len", trial_log.size(), 6);
        for (int i = 0; i < 6 && i < trial_log.size(); i++) chk("t100_seq", trial_log[i], lit100[i]);
        chk("t100_result", bus.result, 100);
        chk("t100_found", bus.found, 1);

        do_run(0, 0, 3'b000, 0);
        chk("t0_done_cyc", last_done_cyc, 9);
        chk("t0_last_trial", trial_log.size() == 8 ? trial_log[7] : -1, 1);
        chk("t0_result", bus.result, 0);
        chk("t0_found", bus.found, 0);

        do_run(255, 0, 3'b000, 0);
        chk("t255_done_cyc", last_done_cyc, 9);
        chk("t255_last_trial", trial_log.size() == 8 ? trial_log[7] : -1, 255);
        chk("t255_result", bus.result, 255);
        chk("t255_found", bus.found, 1);

        do_run(37, 3, 3'b000, 0);
        chk("t37err_done_cyc", last_done_cyc, 4);
        chk("t37err_err", bus.err, 1);
        chk("t37err_found", bus.found, 0);
        chk("t37err_result", bus.result, 32);

        // Abort in search cycle 4 with an asynchronous reset.
        tgt = 100; force_cyc = 0;
        d0 = done_count;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        n = 0;
        while (cyc != 3 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_trial", bus.trial, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_result", bus.result, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("abort_no_done", done_count - d0, 0);
        do_run(100, 0, 3'b000, 0);
        chk("after_abort_result", bus.result, 100);

        d0 = done_count;
        do_run(200, 0, 3'b000, 2);
        repeat (3) @(posedge clk);
        chk("busy_start_dones", done_count - d0, 1);
        chk("busy_start_result", bus.result, 200);

        // start held high re-triggers once back in IDLE
        tgt = 77; force_cyc = 0;
        d0 = done_count;
        dn = 0; n = 0;
        @(posedge clk); #1 bus.start = 1'b1;
        while (dn < 2 && n < 60) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) dn++;
            n++;
        end
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        chk("held_start_dones", done_count - d0, 2);
        chk("held_start_result", bus.result, 77);

        for (int r = 0; r < 40; r++) begin
            int t, fc, pa;
            t  = $urandom_range(0, 255);
            fc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0;
            pa = ($urandom_range(0, 4) == 0) ? 2 : 0;
            do_run(t, fc, bad_flags[$urandom_range(0, 4)], pa);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
